// File: rtl/instru_loader.sv
// instru_loader
//  Loads the instruction memory from a byte stream. Bytes arrive MSB first and
//  are packed into 32-bit words, which are written from word address 0 upward.
//  When a HALT word is written, every remaining word is filled with HALT. The
//  CPU is held while a load is in progress.
//
// Ports
//  clk       rising-edge clock for all state
//  rst       synchronous, active-high reset
//  start     begins a load; honoured only in IDLE or DONE
//  in_valid  a byte is available on in_data
//  in_data   instruction byte, most significant byte of the word first
//  in_ready  a byte is accepted this cycle (high only in RECV)
//  im_we     memory write strobe, one cycle per word
//  im_addr   byte address of the write (word_cnt << 2); holds while idle
//  im_wdata  word to write; holds while idle
//  cpu_hold  keeps the processor stalled while a load is running
//  done      load is complete and every word has been written
//  word_cnt  number of words written so far (0..SIZE_IM)
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RECV   | assembling a word from incoming bytes
// WRITE  | single-cycle write of the assembled word
// FILL   | writing HALT to each remaining word, one per cycle
// DONE   | memory fully written; start begins a reload
module instru_loader #(
   parameter int          SIZE_IM   = 128,
   parameter logic [31:0] HALT_WORD = 32'hFC000000,
   localparam int         CW        = $clog2(SIZE_IM) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          im_we,
   output logic [31:0]   im_addr,
   output logic [31:0]   im_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic [CW-1:0] word_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_FILL,
      S_DONE
   } state_t;

   localparam logic [CW-1:0] LAST_WORD = CW'(SIZE_IM - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] word_cnt_q, word_cnt_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   // The top byte of the word is never needed before the 4th byte arrives,
   // so only three bytes are kept.
   logic [23:0]   shreg_q, shreg_d;
   logic [31:0]   im_addr_q, im_addr_d;
   logic [31:0]   im_wdata_q, im_wdata_d;

   function automatic logic [31:0] addr_of(input logic [CW-1:0] cnt);
      return {{(32 - CW - 2){1'b0}}, cnt, 2'b00};
   endfunction

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      shreg_d    = shreg_q;
      im_addr_d  = im_addr_q;
      im_wdata_d = im_wdata_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_RECV;
               word_cnt_d = '0;
               byte_idx_d = '0;
            end
         end
         S_RECV: begin
            if (in_valid) begin
               shreg_d    = {shreg_q[15:0], in_data};
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  state_d    = S_WRITE;
                  im_wdata_d = {shreg_q, in_data};
                  im_addr_d  = addr_of(word_cnt_q);
               end
            end
         end
         S_WRITE: begin
            word_cnt_d = word_cnt_q + 1'b1;
            // Running out of memory takes priority over starting the fill.
            if (word_cnt_q == LAST_WORD) begin
               state_d = S_DONE;
            end else if (im_wdata_q == HALT_WORD) begin
               state_d   = S_FILL;
               im_addr_d = addr_of(word_cnt_q + 1'b1);
            end else begin
               state_d = S_RECV;
            end
         end
         S_FILL: begin
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == LAST_WORD) begin
               state_d = S_DONE;
            end else begin
               im_addr_d = addr_of(word_cnt_q + 1'b1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         word_cnt_q <= '0;
         byte_idx_q <= '0;
         shreg_q    <= '0;
         im_addr_q  <= '0;
         im_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         shreg_q    <= shreg_d;
         im_addr_q  <= im_addr_d;
         im_wdata_q <= im_wdata_d;
      end
   end

   assign in_ready = (state_q == S_RECV);
   assign im_we    = (state_q == S_WRITE) || (state_q == S_FILL);
   assign cpu_hold = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_FILL);
   assign done     = (state_q == S_DONE);
   assign word_cnt = word_cnt_q;
   assign im_addr  = im_addr_q;
   assign im_wdata = im_wdata_q;

endmodule

// File: tb/tb_instru_loader.sv
// Testbench for instru_loader: drives byte streams with several valid patterns
// and compares the captured memory writes against a word-level load model.
module tb_instru_loader;

   localparam int          SIZE_IM = 128;
   localparam logic [31:0] HALT    = 32'hFC000000;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, im_we, cpu_hold, done;
   logic [31:0] im_addr, im_wdata;
   logic [7:0]  word_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] got_addr[$];
   logic [31:0] got_data[$];
   int          got_cyc[$];
   int          ncyc = 0;

   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];

   instru_loader dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .cpu_hold (cpu_hold),
      .done     (done),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   // write monitor, sampled mid-cycle
   always @(negedge clk) begin
      ncyc <= ncyc + 1;
      if (im_we) begin
         got_addr.push_back(im_addr);
         got_data.push_back(im_wdata);
         got_cyc.push_back(ncyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory-image view of a load: whole words in order until HALT or a full
   // memory, then HALT padding. Returns bytes consumed and the HALT word index.
   task automatic model(input bq_t b, output int consumed, output int halt_idx);
      int words = 0;
      logic [31:0] w;
      exp_addr.delete();
      exp_data.delete();
      consumed = 0;
      halt_idx = -1;
      for (int i = 0; i + 3 < b.size() && words < SIZE_IM; i += 4) begin
         w = {b[i], b[i+1], b[i+2], b[i+3]};
         exp_addr.push_back(words * 4);
         exp_data.push_back(w);
         words++;
         consumed += 4;
         if (w == HALT) begin
            halt_idx = words - 1;
            while (words < SIZE_IM) begin
               exp_addr.push_back(words * 4);
               exp_data.push_back(HALT);
               words++;
            end
            break;
         end
      end
      // trailing partial word is still accepted but never written
      if (words < SIZE_IM && halt_idx < 0) consumed = b.size();
   endtask

   // mode 0: always valid, 1: valid toggles, 2: random valid and random start pulses
   task automatic drive_bytes(input bq_t b, input int mode, output int acc);
      int   guard = 0;
      logic v = 1'b0;
      logic rdy;
      acc = 0;
      while (guard < 3000) begin
         @(negedge clk);
         start    = 1'b0;
         in_valid = 1'b0;
         if (done || acc >= b.size()) break;
         guard++;
         case (mode)
            0:       v = 1'b1;
            1:       v = ~v;
            default: begin
               v     = ($urandom_range(0, 2) != 0);
               start = ($urandom_range(0, 7) == 0);
            end
         endcase
         in_valid = v;
         in_data  = b[acc];
         rdy      = in_ready;
         @(posedge clk);
         if (v && rdy) begin
            acc++;
            if (acc % 4 == 0) begin
               #1;
               chk("lat_we", im_we, 1'b1);
               chk("lat_addr", im_addr, (acc / 4 - 1) * 4);
               chk("lat_rdy", in_ready, 1'b0);
            end
         end
      end
      if (guard >= 3000) chk("drive_timeout", guard, 0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("st_hold", cpu_hold, 1'b1);
      chk("st_rdy", in_ready, 1'b1);
      chk("st_done", done, 1'b0);
      chk("st_cnt", word_cnt, 0);
   endtask

   task automatic run_load(input bq_t b, input int mode);
      int consumed, halt_idx, acc, g, n;
      model(b, consumed, halt_idx);
      @(posedge clk);
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
      pulse_start();
      drive_bytes(b, mode, acc);
      g = 0;
      while (!done && g < 400) begin
         @(negedge clk);
         g++;
      end
      chk("done", done, 1'b1);
      repeat (4) @(negedge clk);
      chk("consumed", acc, consumed);
      chk("n_writes", got_addr.size(), exp_addr.size());
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int k = 0; k < n; k++) begin
         chk($sformatf("addr%0d", k), got_addr[k], exp_addr[k]);
         chk($sformatf("data%0d", k), got_data[k], exp_data[k]);
         if (halt_idx >= 0 && k > halt_idx)
            chk($sformatf("fill_gap%0d", k), got_cyc[k] - got_cyc[k-1], 1);
      end
      chk("end_done", done, 1'b1);
      chk("end_cnt", word_cnt, SIZE_IM);
      chk("end_hold", cpu_hold, 1'b0);
      chk("end_rdy", in_ready, 1'b0);
      chk("end_we", im_we, 1'b0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t s, r;
      logic [31:0] w;
      int acc;

      // reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_rdy", in_ready, 1'b0);
      chk("rst_we", im_we, 1'b0);
      chk("rst_addr", im_addr, 0);
      chk("rst_wdata", im_wdata, 0);
      chk("rst_hold", cpu_hold, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cnt", word_cnt, 0);

      // program then HALT, contiguous and with toggled valid
      s = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
      run_load(s, 0);
      run_load(s, 1);

      // full memory of non-HALT words, one extra byte offered
      s.delete();
      for (int n = 0; n < SIZE_IM; n++) begin
         w = n;
         s.push_back(w[31:24]); s.push_back(w[23:16]);
         s.push_back(w[15:8]);  s.push_back(w[7:0]);
      end
      s.push_back(8'hAA);
      run_load(s, 0);

      // reset after a partial word
      @(posedge clk);
      got_addr.delete();
      got_data.delete();
      got_cyc.delete();
      pulse_start();
      r = '{8'h11, 8'h22};
      drive_bytes(r, 0, acc);
      chk("part_acc", acc, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_hold", cpu_hold, 1'b0);
      chk("mid_rst_rdy", in_ready, 1'b0);
      chk("mid_rst_cnt", word_cnt, 0);
      repeat (3) @(negedge clk);
      chk("mid_rst_we", got_addr.size(), 0);
      s = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFC, 8'h00, 8'h00, 8'h00};
      run_load(s, 0);

      // random programs with random valid gaps and stray start pulses
      for (int t = 0; t < 6; t++) begin
         s.delete();
         for (int n = $urandom_range(0, 12); n > 0; n--) begin
            w = $urandom;
            if (w == HALT) w = w ^ 32'h1;
            s.push_back(w[31:24]); s.push_back(w[23:16]);
            s.push_back(w[15:8]);  s.push_back(w[7:0]);
         end
         s.push_back(8'hFC); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00);
         run_load(s, 2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
